// File: rtl/dbus_mem_resp_pkg.sv
// Shared widths and FSM encoding for the dbus memory responder.
package dbus_mem_resp_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemBus     = 32;
    localparam int SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dbus_mem_resp_array.sv
// Single-port word RAM with per-byte write enables; synchronous read and write.
module dbus_mem_array
    import dbus_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [SEL_WIDTH-1:0]           be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [MemBus-1:0]              wdata,
    output logic [MemBus-1:0]              rdata
);

    logic [MemBus-1:0] mem [DEPTH_WORDS];

    // Read returns the pre-write contents when a read and write share an edge.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_mem_resp.sv
// Multi-cycle dbus memory slave: grant, fixed wait states, then a one-cycle response.
module dbus_mem_resp
    import dbus_mem_resp_pkg::*;
#(
    parameter logic [MemAddrBus-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    DEPTH_WORDS = 4096,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [MemAddrBus-1:0] addr_i,
    input  logic [MemBus-1:0]     wdata_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [MemBus-1:0]     rdata_o,
    output logic                  err_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       grant;

    logic                  we_q;
    logic                  in_range_q;
    logic [AW-1:0]         idx_q;
    logic [MemBus-1:0]     wdata_q;
    logic [SEL_WIDTH-1:0]  sel_q;

    logic [MemAddrBus-1:0] offset;
    logic                  in_range;
    logic [AW-1:0]         idx;

    logic                  acc_we;
    logic                  acc_in_range;
    logic [SEL_WIDTH-1:0]  acc_sel;
    logic                  mem_en;
    logic [SEL_WIDTH-1:0]  mem_be;
    logic [AW-1:0]         mem_addr;
    logic [MemBus-1:0]     mem_wdata;
    logic [MemBus-1:0]     mem_rdata;

    // Unsigned difference: addresses below the base wrap to huge offsets and fail.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[AW+1:2];

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        grant         = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    grant = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (grant) begin
                we_q       <= we_i;
                in_range_q <= in_range;
                idx_q      <= idx;
                wdata_q    <= wdata_i;
                sel_q      <= sel_i;
            end
        end
    end

    // With zero wait states the access edge is the grant edge, so use live inputs.
    always_comb begin
        if (state == IDLE) begin
            acc_we       = we_i;
            acc_in_range = in_range;
            acc_sel      = sel_i;
            mem_addr     = idx;
            mem_wdata    = wdata_i;
        end else begin
            acc_we       = we_q;
            acc_in_range = in_range_q;
            acc_sel      = sel_q;
            mem_addr     = idx_q;
            mem_wdata    = wdata_q;
        end
    end

    assign mem_en = (state_next == RESP) && (state != RESP) && !rst;
    assign mem_be = (acc_we && acc_in_range) ? acc_sel : '0;

    dbus_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (mem_en),
        .be   (mem_be),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    assign gnt_o    = grant && !rst;
    assign rvalid_o = (state == RESP);
    assign err_o    = rvalid_o && !in_range_q;
    assign rdata_o  = (rvalid_o && !we_q && in_range_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dbus_mem_resp.sv
// Scoreboard bench for dbus_mem_resp at WAIT_CYCLES = 2 and 0 sharing one stimulus stream.
module tb_dbus_mem_resp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;

    logic        gnt2, rvalid2, err2;
    logic [31:0] rdata2;
    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    dbus_mem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .sel_i(sel), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
    );

    dbus_mem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .sel_i(sel), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Expected response for a request, updating the reference memory on in-range writes.
    function automatic exp_t predict(input string tag, input logic w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        logic [31:0] offs;
        logic [31:0] word;
        bit          inr;
        int          idx;
        offs  = a - 32'h8000_0000;
        inr   = offs < 32'h0000_4000;
        idx   = int'(offs[13:2]);
        e.tag = tag;
        e.err = !inr;
        if (w) begin
            e.rdata = 32'h0;
            if (inr) begin
                word = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
                for (int l = 0; l < 4; l++) begin
                    if (s[l]) word[8*l +: 8] = d[8*l +: 8];
                end
                model[idx] = word;
            end
        end else begin
            e.rdata = inr ? model[idx] : 32'h0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d; sel = s;
        n = 0;
        @(negedge clk);
        while (!gnt2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!gnt2) begin
            checkOutput({tag, "_gnt_timeout"}, 32'd0, 32'd1);
            req = 1'b0;
            return;
        end
        sb.push_back(predict(tag, w, a, d, s));
        @(posedge clk); #1;
        req   = 1'b0;
        we    = ~w;
        addr  = $urandom;
        wdata = $urandom;
        sel   = 4'($urandom);
        repeat (5) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rvalid2) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rvalid", 32'(rvalid2), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.tag, "_rdata"}, rdata2, mon_e.rdata);
                checkOutput({mon_e.tag, "_err"}, 32'(err2), 32'(mon_e.err));
            end
        end
    end

    initial begin
        int   n;
        int   rv_count;
        exp_t e;

        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_gnt2", 32'(gnt2), 32'd0);
        checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid2), 32'd0);
        checkOutput("rst_rdata", rdata2, 32'd0);
        checkOutput("rst_err", 32'(err2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_gnt", 32'(gnt2), 32'd1);
        sb.push_back(predict("post_rst_oor", 1'b0, 32'h0, 32'h0, 4'h0));
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);

        applyStimulus("wr_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        applyStimulus("rd_full", 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        applyStimulus("wr_lane1", 1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010);
        applyStimulus("rd_lane1", 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        applyStimulus("wr_sel0", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
        applyStimulus("rd_sel0", 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        applyStimulus("rd_oor_zero", 1'b0, 32'h0000_0000, 32'h0, 4'h0);
        applyStimulus("rd_oor_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
        applyStimulus("wr_word0", 1'b1, 32'h8000_0000, 32'h1111_2222, 4'hF);
        applyStimulus("wr_oor_top", 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
        applyStimulus("rd_word0", 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        applyStimulus("wr_last", 1'b1, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF);
        applyStimulus("rd_last", 1'b0, 32'h8000_3FFF, 32'h0, 4'h0);
        applyStimulus("wr_prev20", 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);

        // Abort a write by pulsing reset in its first wait cycle.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h8000_0020; wdata = 32'h1234_5678; sel = 4'hF;
        @(negedge clk);
        checkOutput("abort_gnt", 32'(gnt2), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rv_count = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rvalid2) rv_count++;
        end
        checkOutput("abort_no_rvalid", 32'(rv_count), 32'd0);
        applyStimulus("rd_after_abort", 1'b0, 32'h8000_0020, 32'h0, 4'h0);

        // Back-to-back reads with req held: grant every W+2 cycles, response W+1 after grant.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h8000_0010; wdata = 32'h0; sel = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("tp_gnt2_c%0d", c), 32'(gnt2), 32'((c % 4) == 0));
            checkOutput($sformatf("tp_rvalid2_c%0d", c), 32'(rvalid2), 32'((c % 4) == 3));
            checkOutput($sformatf("tp_gnt0_c%0d", c), 32'(gnt0), 32'((c % 2) == 0));
            checkOutput($sformatf("tp_rvalid0_c%0d", c), 32'(rvalid0), 32'((c % 2) == 1));
            if (rvalid0) checkOutput($sformatf("tp_rdata0_c%0d", c), rdata0, model[4]);
            if (gnt2) begin
                e = predict($sformatf("tp_rd_c%0d", c), 1'b0, 32'h8000_0010, 32'h0, 4'h0);
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        req = 1'b0;

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
